data_io: RTL and testbench

DATA_IO -- requirements
Module: data_io

---
 rtl/data_io_pkg.sv | 16 +
 rtl/spi_sync.sv | 28 ++
 rtl/data_io.sv | 145 ++++++++++++++
 tb/tb_data_io.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_io_pkg.sv
// Shared constants and types for the SPI download block: command codes,
// frame decode states and the address width.
package data_io_pkg;

   localparam int ADDR_W = 25;

   localparam logic [7:0] CMD_FILE_TX     = 8'h53;
   localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
   localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

   typedef enum logic {
      CMD,
      CMD_DONE
   } state_t;

endpackage

// File: rtl/spi_sync.sv
// Brings the three SPI pins into the system clock domain and flags rising
// edges of SCK; DI and SS2 are delayed to line up with the SCK edge flag.
module spi_sync (
   input  logic i_clk,
   input  logic i_sck,
   input  logic i_ss_n,
   input  logic i_di,
   output logic o_sck_rise,
   output logic o_ss_n,
   output logic o_di
);

   logic [2:0] r_sck;
   logic [1:0] r_ss_n;
   logic [1:0] r_di;

   // Pure pin samplers: they always mirror the pins, so they carry no reset
   always_ff @(posedge i_clk) begin
      r_sck  <= {r_sck[1:0], i_sck};
      r_ss_n <= {r_ss_n[0], i_ss_n};
      r_di   <= {r_di[0], i_di};
   end

   assign o_sck_rise = r_sck[1] & ~r_sck[2];
   assign o_ss_n     = r_ss_n[1];
   assign o_di       = r_di[1];

endmodule

// File: rtl/data_io.sv
// SPI download slave: decodes command frames from the ARM and turns
// FILE_TX_DAT payload bytes into clkref-qualified byte writes.
module data_io
   import data_io_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_ADDR = 25'h0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              SPI_SCK,
   input  logic              SPI_SS2,
   input  logic              SPI_DI,
   inout  wire               SPI_DO,
   input  logic              clkref_n,
   output logic              ioctl_download,
   output logic [7:0]        ioctl_index,
   output logic              ioctl_wr,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout
);

   logic w_sck_rise;
   logic w_ss_n;
   logic w_di;

   spi_sync u_sync (
      .i_clk      (clk_sys),
      .i_sck      (SPI_SCK),
      .i_ss_n     (SPI_SS2),
      .i_di       (SPI_DI),
      .o_sck_rise (w_sck_rise),
      .o_ss_n     (w_ss_n),
      .o_di       (w_di)
   );

   assign SPI_DO = 1'bz;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_bitcnt;
   logic [6:0]        r_shift;
   logic [7:0]        r_cmd;
   logic              r_armed;
   logic              r_pending;
   logic              r_download;
   logic [7:0]        r_index;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_dout;

   logic       w_bit_en;
   logic       w_byte_done;
   logic [7:0] w_byte;
   logic       w_issue;

   // r_armed keeps a frame that was cut by reset from being decoded mid-way
   assign w_bit_en    = r_armed & ~w_ss_n & w_sck_rise;
   assign w_byte      = {r_shift, w_di};
   assign w_byte_done = w_bit_en & (r_bitcnt == 3'd7);
   // A byte landing this cycle defers the strobe so it covers the newest data
   assign w_issue     = r_pending & ~clkref_n & ~w_byte_done;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= CMD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_ss_n) begin
         w_state_nxt = CMD;
      end else if (w_byte_done && (r_state == CMD)) begin
         w_state_nxt = CMD_DONE;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_bitcnt   <= 3'd0;
         r_shift    <= 7'd0;
         r_cmd      <= 8'd0;
         r_armed    <= 1'b0;
         r_pending  <= 1'b0;
         r_download <= 1'b0;
         r_index    <= 8'd0;
         r_wr       <= 1'b0;
         r_addr     <= START_ADDR;
         r_dout     <= 8'd0;
      end else begin
         r_wr <= w_issue & r_download;
         if (w_issue) begin
            r_pending <= 1'b0;
         end
         if (r_wr) begin
            r_addr <= r_addr + ADDR_W'(1);
         end

         if (w_ss_n) begin
            r_bitcnt <= 3'd0;
            r_armed  <= 1'b1;
         end else if (w_bit_en) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= w_byte[6:0];
         end

         if (w_byte_done) begin
            if (r_state == CMD) begin
               r_cmd <= w_byte;
            end else begin
               case (r_cmd)
                  CMD_FILE_TX: begin
                     if (w_byte != 8'h00) begin
                        r_download <= 1'b1;
                        r_addr     <= START_ADDR;
                     end else begin
                        r_download <= 1'b0;
                     end
                  end
                  CMD_FILE_TX_DAT: begin
                     r_dout <= w_byte;
                     if (r_download) begin
                        r_pending <= 1'b1;
                     end
                  end
                  CMD_FILE_INDEX: begin
                     r_index <= w_byte;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign ioctl_download = r_download;
   assign ioctl_index    = r_index;
   assign ioctl_wr       = r_wr;
   assign ioctl_addr     = r_addr;
   assign ioctl_dout     = r_dout;

endmodule

// File: tb/tb_data_io.sv
// Bench for data_io: vector table, hand-built clkref/reset/wrap sequences and
// random frames compared with a byte-level model of the command rules.
module tb_data_io;

   logic clk_sys  = 1'b0;
   logic reset    = 1'b1;
   logic SPI_SCK  = 1'b0;
   logic SPI_SS2  = 1'b1;
   logic SPI_DI   = 1'b0;
   logic clkref_n = 1'b0;
   wire  spi_do1;
   wire  spi_do2;

   logic        dl1, wr1, dl2, wr2;
   logic [7:0]  idx1, dout1, idx2, dout2;
   logic [24:0] addr1, addr2;

   always #5 clk_sys = ~clk_sys;

   data_io u_dut1 (
      .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2),
      .SPI_DI(SPI_DI), .SPI_DO(spi_do1), .clkref_n(clkref_n),
      .ioctl_download(dl1), .ioctl_index(idx1), .ioctl_wr(wr1),
      .ioctl_addr(addr1), .ioctl_dout(dout1)
   );

   data_io #(.START_ADDR(25'h1FFFFFF)) u_dut2 (
      .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2),
      .SPI_DI(SPI_DI), .SPI_DO(spi_do2), .clkref_n(clkref_n),
      .ioctl_download(dl2), .ioctl_index(idx2), .ioctl_wr(wr2),
      .ioctl_addr(addr2), .ioctl_dout(dout2)
   );

   typedef struct packed {
      logic [24:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef logic [7:0] frame_t[$];

   typedef struct packed {
      logic [3:0][7:0] b;
      logic [2:0]      n;
      logic            dl;
      logic [7:0]      idx;
      logic [24:0]     addr;
      logic [7:0]      dout;
      logic [1:0]      nwr;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   wr_t  q1[$];
   wr_t  q2[$];
   wr_t  mq[$];
   logic rand_clkref = 1'b0;

   logic        m_dl;
   logic [7:0]  m_idx;
   logic [24:0] m_addr;
   logic [7:0]  m_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (wr1) begin
         q1.push_back({addr1, dout1});
         n_tests++;
         if (!dl1) begin
            n_fail++;
            $display("FAIL wr_needs_download: wr=1 with download=%0d, expected 1", dl1);
         end
      end
      if (wr2) q2.push_back({addr2, dout2});
      if (rand_clkref) clkref_n = 1'($urandom_range(0, 1));
   end

   initial begin
      repeat (100000) @(posedge clk_sys);
      $display("FAIL watchdog: simulation still running after 100000 cycles, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         SPI_DI = b[7-i];
         repeat (5) @(negedge clk_sys);
         SPI_SCK = 1'b1;
         repeat (5) @(negedge clk_sys);
         SPI_SCK = 1'b0;
      end
   endtask

   task automatic send_frame(input frame_t fr);
      SPI_SS2 = 1'b0;
      repeat (4) @(negedge clk_sys);
      foreach (fr[i]) send_bits(fr[i], 8);
      repeat (4) @(negedge clk_sys);
      SPI_SS2 = 1'b1;
      repeat (40) @(negedge clk_sys);
   endtask

   function automatic void model_reset();
      m_dl = 1'b0; m_idx = 8'h00; m_addr = 25'h0; m_dout = 8'h00;
      mq.delete();
   endfunction

   // Each byte after the command acts on its own, following the command rules
   function automatic void model_frame(input frame_t fr);
      for (int i = 1; i < fr.size(); i++) begin
         case (fr[0])
            8'h53: begin
               if (fr[i] != 0) begin m_dl = 1'b1; m_addr = 25'h0; end
               else m_dl = 1'b0;
            end
            8'h54: begin
               m_dout = fr[i];
               if (m_dl) begin
                  mq.push_back({m_addr, fr[i]});
                  m_addr = m_addr + 25'd1;
               end
            end
            8'h55: m_idx = fr[i];
            default: ;
         endcase
      end
   endfunction

   task automatic check_state(input string tag);
      chk({tag, "_download"}, 32'(dl1), 32'(m_dl));
      chk({tag, "_index"}, 32'(idx1), 32'(m_idx));
      chk({tag, "_addr"}, 32'(addr1), 32'(m_addr));
      chk({tag, "_dout"}, 32'(dout1), 32'(m_dout));
      chk({tag, "_wr_count"}, q1.size(), mq.size());
      for (int i = 0; i < q1.size() && i < mq.size(); i++) begin
         chk({tag, "_wr_addr"}, 32'(q1[i].a), 32'(mq[i].a));
         chk({tag, "_wr_data"}, 32'(q1[i].d), 32'(mq[i].d));
      end
      q1.delete();
      mq.delete();
   endtask

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n,
                               input logic dl, input logic [7:0] idx,
                               input logic [24:0] addr, input logic [7:0] dout,
                               input int nwr);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.n = 3'(n); v.dl = dl; v.idx = idx; v.addr = addr; v.dout = dout;
      v.nwr = 2'(nwr);
      return v;
   endfunction

   vec_t   tbl[8];
   frame_t fr;

   initial begin
      tbl[0] = mk(8'h55, 8'h00, 8'h00, 8'h00, 2, 1'b0, 8'h00, 25'h0, 8'h00, 0);
      tbl[1] = mk(8'h53, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 8'h00, 25'h0, 8'h00, 0);
      tbl[2] = mk(8'h54, 8'hAA, 8'h55, 8'h01, 4, 1'b1, 8'h00, 25'h3, 8'h01, 3);
      tbl[3] = mk(8'h53, 8'h00, 8'h00, 8'h00, 2, 1'b0, 8'h00, 25'h3, 8'h01, 0);
      tbl[4] = mk(8'h54, 8'h12, 8'h00, 8'h00, 2, 1'b0, 8'h00, 25'h3, 8'h12, 0);
      tbl[5] = mk(8'h55, 8'hA7, 8'h00, 8'h00, 2, 1'b0, 8'hA7, 25'h3, 8'h12, 0);
      tbl[6] = mk(8'h42, 8'h53, 8'hFF, 8'h00, 3, 1'b0, 8'hA7, 25'h3, 8'h12, 0);
      tbl[7] = mk(8'h53, 8'h01, 8'h00, 8'h00, 2, 1'b1, 8'hA7, 25'h0, 8'h12, 0);

      // Reset values
      repeat (5) @(negedge clk_sys);
      chk("rst_download", 32'(dl1), 32'h0);
      chk("rst_wr", 32'(wr1), 32'h0);
      chk("rst_index", 32'(idx1), 32'h0);
      chk("rst_addr", 32'(addr1), 32'h0);
      chk("rst_dout", 32'(dout1), 32'h0);
      chk("rst_addr_top", 32'(addr2), 32'h1FFFFFF);
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk_sys);

      // Vector table
      foreach (tbl[k]) begin
         fr.delete();
         for (int j = 0; j < int'(tbl[k].n); j++) fr.push_back(tbl[k].b[j]);
         send_frame(fr);
         model_frame(fr);
         chk("tbl_download", 32'(dl1), 32'(tbl[k].dl));
         chk("tbl_index", 32'(idx1), 32'(tbl[k].idx));
         chk("tbl_addr", 32'(addr1), 32'(tbl[k].addr));
         chk("tbl_dout", 32'(dout1), 32'(tbl[k].dout));
         chk("tbl_nwr", q1.size(), int'(tbl[k].nwr));
         check_state("tbl_model");
      end

      // clkref_n held high during a data byte, released 10 cycles later
      clkref_n = 1'b1;
      fr = {8'h54, 8'h5A};
      send_frame(fr);
      chk("hold_no_wr", q1.size(), 0);
      repeat (10) @(negedge clk_sys);
      clkref_n = 1'b0;
      @(negedge clk_sys);
      chk("hold_wr_first_low", 32'(wr1), 32'h1);
      chk("hold_wr_addr", 32'(addr1), 32'h0);
      chk("hold_wr_dout", 32'(dout1), 32'h5A);
      @(negedge clk_sys);
      chk("hold_wr_single", 32'(wr1), 32'h0);
      chk("hold_addr_inc", 32'(addr1), 32'h1);
      q1.delete();
      model_frame(fr);
      mq.delete();

      // Two bytes land while clkref_n is high: newest byte, one strobe
      clkref_n = 1'b1;
      fr = {8'h54, 8'hC1, 8'hC2};
      send_frame(fr);
      chk("ovr_no_wr", q1.size(), 0);
      clkref_n = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("ovr_wr_count", q1.size(), 1);
      if (q1.size() > 0) chk("ovr_wr_item", 32'(q1[0]), 32'({25'h1, 8'hC2}));
      m_addr = 25'h2; m_dout = 8'hC2;
      q1.delete();
      mq.delete();
      check_state("ovr");

      // Reset mid-byte during a download; rest of that frame must be ignored
      SPI_SS2 = 1'b0;
      repeat (4) @(negedge clk_sys);
      send_bits(8'h54, 8);
      send_bits(8'hE7, 4);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      chk("mid_rst_download", 32'(dl1), 32'h0);
      chk("mid_rst_wr", 32'(wr1), 32'h0);
      chk("mid_rst_index", 32'(idx1), 32'h0);
      chk("mid_rst_addr", 32'(addr1), 32'h0);
      chk("mid_rst_dout", 32'(dout1), 32'h0);
      reset = 1'b0;
      model_reset();
      send_bits(8'h70, 4);
      send_bits(8'h55, 8);
      send_bits(8'h99, 8);
      repeat (4) @(negedge clk_sys);
      SPI_SS2 = 1'b1;
      repeat (40) @(negedge clk_sys);
      check_state("post_rst_ignored");
      fr = {8'h55, 8'h3C};
      send_frame(fr);
      model_frame(fr);
      check_state("post_rst_index");
      fr = {8'h53, 8'h01};
      send_frame(fr);
      model_frame(fr);
      check_state("post_rst_tx");

      // Random frames against the model, clkref_n toggling randomly
      rand_clkref = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int kind;
         logic [7:0] c;
         kind = $urandom_range(0, 3);
         fr.delete();
         case (kind)
            0: begin
               fr.push_back(8'h53);
               fr.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            end
            1: begin
               fr.push_back(8'h54);
               repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom));
            end
            2: begin
               fr.push_back(8'h55);
               fr.push_back(8'($urandom));
            end
            default: begin
               c = 8'($urandom);
               while (c >= 8'h53 && c <= 8'h55) c = 8'($urandom);
               fr.push_back(c);
               repeat ($urandom_range(1, 3)) fr.push_back(8'($urandom));
            end
         endcase
         send_frame(fr);
         model_frame(fr);
         check_state("rand");
      end
      rand_clkref = 1'b0;
      clkref_n = 1'b0;
      repeat (5) @(negedge clk_sys);

      // Address wrap on the instance that starts at the top of the range
      q2.delete();
      fr = {8'h53, 8'h01};
      send_frame(fr);
      model_frame(fr);
      chk("wrap_start_addr", 32'(addr2), 32'h1FFFFFF);
      fr = {8'h54, 8'h11, 8'h22};
      send_frame(fr);
      model_frame(fr);
      chk("wrap_wr_count", q2.size(), 2);
      if (q2.size() > 1) begin
         chk("wrap_wr0", 32'(q2[0]), 32'({25'h1FFFFFF, 8'h11}));
         chk("wrap_wr1", 32'(q2[1]), 32'({25'h0, 8'h22}));
      end
      chk("wrap_final_addr", 32'(addr2), 32'h1);
      check_state("wrap_ref");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
